// File: rtl/r3_from_rq_poly_if.sv
// Control handshake and RAM ports of the Rq to R3 reducer.
// The slave side is the reducer, the master side its sequencer and RAMs.
interface r3_from_rq_poly_if #(
  parameter int AW = 11,
  parameter int CW = 13
);
  logic          start;
  logic [AW-1:0] n_coef;
  logic          busy;
  logic          done;
  logic [AW-1:0] weight;
  logic          err;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [CW-1:0] rd_data;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [1:0]    wr_data;

  modport slave (
    input  start, n_coef, rd_data,
    output busy, done, weight, err,
    output rd_en, rd_addr, wr_en, wr_addr, wr_data
  );

  modport master (
    output start, n_coef, rd_data,
    input  busy, done, weight, err,
    input  rd_en, rd_addr, wr_en, wr_addr, wr_data
  );
endinterface

// File: rtl/r3_from_rq_poly.sv
// Streams Rq coefficients, centres and reduces them mod 3,
// writes ternary codes and counts the nonzero ones.
module r3_from_rq_poly #(
  parameter int P  = 757,
  parameter int Q  = 5167,
  parameter int AW = 11,
  parameter int CW = 13
) (
  input  logic               clk,
  input  logic               rst,
  r3_from_rq_poly_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t        state;
  state_t        state_nx;
  logic [AW-1:0] nreg;
  logic [AW-1:0] cnt;
  logic          dcnt;
  logic          v1;
  logic [AW-1:0] a1;
  logic [CW-1:0] m_full;
  logic [1:0]    m;
  logic          hi;
  logic [1:0]    code;
  logic          go;

  assign go = (state == IDLE) && bus.start;

  // Q mod 3 = 1, so the upper half shifts the residue down by one;
  // residue 0/1/2 then matches code 00/01/10 directly.
  assign m_full = bus.rd_data % CW'(3);
  assign m      = m_full[1:0];
  assign hi     = bus.rd_data > CW'((Q - 1) / 2);

  always_comb begin
    code = m;
    if (hi) code = (m == 2'd0) ? 2'd2 : m - 2'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (1'b1)
      state == IDLE: begin
        if (bus.start)
          state_nx = (bus.n_coef == '0) ? DRAIN : READ;
      end
      state == READ: begin
        if (cnt == nreg - AW'(1)) state_nx = DRAIN;
      end
      state == DRAIN: begin
        if (dcnt) state_nx = DONE;
      end
      state == DONE: state_nx = IDLE;
      default:       state_nx = IDLE;
    endcase
  end

  always_comb begin
    bus.busy    = (state == READ) || (state == DRAIN);
    bus.done    = (state == DONE);
    bus.rd_en   = (state == READ);
    bus.rd_addr = (state == READ) ? cnt : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      nreg        <= '0;
      cnt         <= '0;
      dcnt        <= 1'b0;
      v1          <= 1'b0;
      a1          <= '0;
      bus.wr_en   <= 1'b0;
      bus.wr_addr <= '0;
      bus.wr_data <= 2'b00;
      bus.weight  <= '0;
      bus.err     <= 1'b0;
    end else begin
      // An empty job spends a single cycle in DRAIN.
      dcnt <= (state == DRAIN) || (go && bus.n_coef == '0);
      if (go) begin
        nreg       <= (bus.n_coef > AW'(P)) ? AW'(P) : bus.n_coef;
        cnt        <= '0;
        bus.weight <= '0;
        bus.err    <= 1'b0;
      end
      if (state == READ) cnt <= cnt + AW'(1);
      v1        <= (state == READ);
      a1        <= cnt;
      bus.wr_en <= v1;
      if (v1) begin
        bus.wr_addr <= a1;
        bus.wr_data <= code;
        bus.weight  <= bus.weight + AW'(code != 2'b00);
        if (bus.rd_data >= CW'(Q)) bus.err <= 1'b1;
      end
    end
  end

endmodule
